// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: parallel load, logical/arithmetic shifts and
// rotates in both directions, one bit position per clock under a start/busy/done handshake.
module universal_shift_reg #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        MODE_NOP  = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           r_state;
    mode_e            r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_done;
    logic [WIDTH-1:0] w_step;
    mode_e            w_mode_in;
    logic             w_is_shift;

    assign w_mode_in  = mode_e'(mode);
    assign w_is_shift = (w_mode_in inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});

    // NOTE: assign a default before the case so no path leaves w_step unassigned (no latch).
    always_comb begin
        w_step = r_q;
        case (r_mode)
            MODE_SHL: w_step = {r_q[WIDTH-2:0], sin_r};
            MODE_SHR: w_step = {sin_l, r_q[WIDTH-1:1]};
            MODE_ROL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROR: w_step = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ASR: w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default:  w_step = r_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_NOP;
            r_cnt   <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= w_mode_in;
                        r_cnt  <= amt;
                        if (w_mode_in == MODE_LOAD) begin
                            r_q    <= d;
                            r_done <= 1'b1;
                        end else if (w_is_shift && (amt != '0)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = (r_state == ST_RUN);
    assign done   = r_done;

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the 4-bit parallel-in/parallel-out register. Supports parallel load, logical and arithmetic shifts, and rotates in either direction. Multi-bit shifts run one position per clock, under a start/busy/done handshake driven by a small controller. Used wherever datapath blocks need a configurable-width shift or rotate stage with serial in/out taps.

Parameters:
WIDTH, 4, register width in bits (>=2)
AMT_W, 3, width of shift-amount input; amount range 0..2^AMT_W-1

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only when busy=0
mode  input  3  0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved (NOP)
amt  input  AMT_W  number of single-bit steps for shift/rotate modes
d  input  WIDTH  parallel load data
sin_l  input  1  serial fill bit for SHR (enters MSB)
sin_r  input  1  serial fill bit for SHL (enters LSB)
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational from q
sout_r  output  1  q[0], combinational from q
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: clear_n=0 immediately forces q=0, busy=0, done=0, state IDLE, and clears the internal counter/mode latch, regardless of clk. This includes mid-operation; an aborted operation produces no done pulse.
- States: IDLE, RUN. busy=1 exactly when state=RUN.
- done is registered. It defaults to 0 every edge and is high for exactly one cycle per accepted command.
- Accept: at a rising edge with state IDLE and start=1, the block latches mode and sets cnt=amt.
  - mode LOAD: q<=d at the accept edge; done<=1 at the same edge; stays IDLE. amt is ignored.
  - mode NOP/7: q unchanged; done<=1; stays IDLE.
  - shift/rotate mode with amt=0: q unchanged; done<=1; stays IDLE.
  - shift/rotate mode with amt>0: q unchanged at accept edge; state<=RUN.
- RUN, on each edge: perform one step using the latched mode; cnt<=cnt-1. On the edge where cnt==1, do the final step, set state<=IDLE and done<=1. The last q value and done are visible in the same cycle.
- Latency: a shift of N steps gives busy=1 for N cycles after the accept edge and done in the cycle after the N-th step edge.
- Step definitions:
  - SHL: q<={q[WIDTH-2:0],sin_r}
  - SHR: q<={sin_l,q[WIDTH-1:1]}
  - ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}
  - ROR: q<={q[0],q[WIDTH-1:1]}
  - ASR: q<={q[WIDTH-1],q[WIDTH-1:1]}
- sin_l/sin_r are sampled at every step edge, not latched at accept.
- amt > WIDTH is legal. Shifts saturate to all-fill; rotates wrap modulo WIDTH naturally.
- start while busy=1 is ignored and not queued. mode, amt and d changes during RUN have no effect.
- start asserted in the same cycle as the final step edge (busy still 1) is ignored. The next command is accepted on the following edge at the earliest.
- start=0 in IDLE: q holds.

Test Plan:
- Reset mid-run: load 1010, start SHL amt=3, pull clear_n low after 1 step -> q=0000, busy=0, done=0 immediately; no done pulse after release.
- Parallel load: d=1011, mode=1, start one cycle -> q=1011 at accept edge, done=1 for one cycle, busy never 1; sout_l=1, sout_r=1.
- SHL fill: from q=1011, mode=2, amt=2, sin_r=1 -> q=0111 then 1111; busy=1 for 2 cycles; done with q=1111.
- Rotate wrap: from q=1001, mode=5, amt=5 -> q sequence 1100,0110,0011,1001,1100; done after 5th step.
- ASR sign fill: from q=1000, mode=6, amt=3 -> 1100,1110,1111. Then mode=3, amt=2, sin_l=0 -> 0111,0011.
- Handshake corners: amt=0 SHR -> done next cycle, q unchanged, busy=0. Start LOAD d=0000 while busy -> ignored, q not zeroed. Back-to-back start held high -> second command accepted only after busy falls, with exactly one done per command.
